spi_master_multi: RTL

Parametrised full-duplex SPI master with configurable word width, SCLK divider, per-transfer mode (CPOL/CPHA), bit order and multi-slave chip select. It is the general-purpose successor to the fixed 8-bit, mode-0, transmit-only SPI master FSM. It sits between a host-side valid/ready word interface and the SPI pins. SCLK is a registered output generated from `clk` and is never used internally as a clock.

---
 rtl/spi_master_multi.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/spi_master_multi.sv
// spi_master_multi
//   Full-duplex SPI master. Takes one word per valid/ready handshake and shifts it
//   out on MOSI while assembling a word from MISO. Word width, SCLK divider,
//   number of chip selects and bit order are parameters. SPI mode (CPOL/CPHA) and
//   the target slave are latched per transfer. SCLK is a registered output
//   derived from clk. It never clocks any internal logic.
//
// Ports
//   clk, rst            system clock, async active-high reset
//   tx_valid/tx_ready   host word handshake (tx_data, tx_cs_sel, cpol, cpha)
//   rx_valid, rx_data   one-cycle pulse with the received word (held until next)
//   busy                transfer in progress
//   sclk, mosi, miso    SPI data/clock pins
//   cs_n                active-low chip selects, one per slave
//
// State  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for a word; sclk tracks the cpol input
// LEAD   | chip select asserted, one half-period of setup before SCLK moves
// SHIFT  | 2*DATA_W SCLK toggles, one per half-period
// TRAIL  | chip select hold, one half-period, then release and report rx
module spi_master_multi #(
    parameter int DATA_W    = 8,
    parameter int CLK_DIV   = 4,
    parameter int NUM_CS    = 1,
    parameter bit LSB_FIRST = 1'b0,
    parameter int CS_W      = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic [DATA_W-1:0] tx_data,
    input  logic [CS_W-1:0]   tx_cs_sel,
    input  logic              cpol,
    input  logic              cpha,
    output logic              rx_valid,
    output logic [DATA_W-1:0] rx_data,
    output logic              busy,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso,
    output logic [NUM_CS-1:0] cs_n
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LEAD  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_TRAIL = 2'd3;

    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int EDGE_W = $clog2(2 * DATA_W + 1);
    localparam logic [DIV_W-1:0]  DIV_LOAD  = DIV_W'(CLK_DIV - 1);
    localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * DATA_W);

    logic [1:0]        state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [EDGE_W-1:0] edge_q, edge_d;
    logic              cpol_q, cpol_d;
    logic              cpha_q, cpha_d;
    logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
    logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              tx_ready_q, tx_ready_d;
    logic              busy_q, busy_d;
    logic              sclk_q, sclk_d;
    logic              mosi_q, mosi_d;
    logic [NUM_CS-1:0] cs_n_q, cs_n_d;

    logic              accept;
    logic              div_exp;
    logic [EDGE_W-1:0] toggle_num;
    logic              sample_edge;
    logic [NUM_CS-1:0] cs_dec;

    function automatic logic first_bit(input logic [DATA_W-1:0] w);
        return LSB_FIRST ? w[0] : w[DATA_W-1];
    endfunction

    function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] w);
        return LSB_FIRST ? {1'b0, w[DATA_W-1:1]} : {w[DATA_W-2:0], 1'b0};
    endfunction

    function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] w, input logic b);
        return LSB_FIRST ? {b, w[DATA_W-1:1]} : {w[DATA_W-2:0], b};
    endfunction

    // An out-of-range select decodes to no active line. The transfer still runs.
    always_comb begin
        cs_dec = '1;
        for (int i = 0; i < NUM_CS; i++) begin
            if (int'(tx_cs_sel) == i) cs_dec[i] = 1'b0;
        end
    end

    assign accept     = tx_valid && tx_ready_q;
    assign div_exp    = (div_q == '0);
    assign toggle_num = edge_q + 1'b1;
    // Odd toggles are leading edges. CPHA=0 samples on leading edges and
    // CPHA=1 samples on trailing edges.
    assign sample_edge = toggle_num[0] ^ cpha_q;

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        edge_d     = edge_q;
        cpol_d     = cpol_q;
        cpha_d     = cpha_q;
        tx_sh_d    = tx_sh_q;
        rx_sh_d    = rx_sh_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        tx_ready_d = tx_ready_q;
        busy_d     = busy_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        cs_n_d     = cs_n_q;

        case (state_q)
            ST_IDLE: begin
                sclk_d     = cpol;
                tx_ready_d = 1'b1;
                if (accept) begin
                    state_d    = ST_LEAD;
                    tx_ready_d = 1'b0;
                    busy_d     = 1'b1;
                    div_d      = DIV_LOAD;
                    edge_d     = '0;
                    cpol_d     = cpol;
                    cpha_d     = cpha;
                    cs_n_d     = cs_dec;
                    // CPHA=0 presents the first bit before the first SCLK edge.
                    if (!cpha) begin
                        mosi_d  = first_bit(tx_data);
                        tx_sh_d = shift_out(tx_data);
                    end else begin
                        mosi_d  = 1'b0;
                        tx_sh_d = tx_data;
                    end
                end
            end
            ST_LEAD: begin
                sclk_d = cpol_q;
                if (div_exp) begin
                    div_d   = DIV_LOAD;
                    state_d = ST_SHIFT;
                end else begin
                    div_d = div_q - 1'b1;
                end
            end
            ST_SHIFT: begin
                if (div_exp) begin
                    div_d  = DIV_LOAD;
                    sclk_d = ~sclk_q;
                    edge_d = toggle_num;
                    if (sample_edge) begin
                        rx_sh_d = shift_in(rx_sh_q, miso);
                    end else if (toggle_num != EDGE_LAST) begin
                        mosi_d  = first_bit(tx_sh_q);
                        tx_sh_d = shift_out(tx_sh_q);
                    end
                    if (toggle_num == EDGE_LAST) state_d = ST_TRAIL;
                end else begin
                    div_d = div_q - 1'b1;
                end
            end
            ST_TRAIL: begin
                sclk_d = cpol_q;
                if (div_exp) begin
                    state_d    = ST_IDLE;
                    cs_n_d     = '1;
                    mosi_d     = 1'b0;
                    rx_data_d  = rx_sh_q;
                    rx_valid_d = 1'b1;
                    tx_ready_d = 1'b1;
                    busy_d     = 1'b0;
                end else begin
                    div_d = div_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            div_q      <= '0;
            edge_q     <= '0;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            tx_sh_q    <= '0;
            rx_sh_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            tx_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            cs_n_q     <= '1;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            edge_q     <= edge_d;
            cpol_q     <= cpol_d;
            cpha_q     <= cpha_d;
            tx_sh_q    <= tx_sh_d;
            rx_sh_q    <= rx_sh_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            tx_ready_q <= tx_ready_d;
            busy_q     <= busy_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            cs_n_q     <= cs_n_d;
        end
    end

    assign tx_ready = tx_ready_q;
    assign rx_valid = rx_valid_q;
    assign rx_data  = rx_data_q;
    assign busy     = busy_q;
    assign sclk     = sclk_q;
    assign mosi     = mosi_q;
    assign cs_n     = cs_n_q;

endmodule
